ddr_multi_ch_init_ctrl: RTL and testbench

- Parametrised N-channel DDR4 bring-up sequencer for the core clock domain.
- Generates a timed reset pulse to every DDR wrapper, waits for all enabled channels to report calibration, and retries on timeout.
- Supervises calibration loss and data-compare errors, then presents one system-ready flag to fpga_top logic.
- Replaces fixed two-channel, timing-by-delay reset generation with a synthesizable, channel-scalable controller.

---
 rtl/ddr_multi_ch_init_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_ddr_multi_ch_init_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_multi_ch_init_ctrl.sv
// N-channel DDR4 bring-up sequencer: timed reset pulse, calibration wait with retry, error supervision.
// Optional per-channel saturating compare-error counters when DDR_ERR_COUNT_EN is defined.
module ddr_multi_ch_init_ctrl #(
    parameter int NUM_CH         = 2,
    parameter int PRE_RST_CYCLES = 60,
    parameter int RST_CYCLES     = 120,
    parameter int TIMEOUT_CYCLES = 1048576,
    parameter int MAX_RETRY      = 3,
    parameter int CNT_W          = 24
) (
    input  logic              core_clk,
    input  logic              sys_rst,
    input  logic [NUM_CH-1:0] ch_enable,
    input  logic [NUM_CH-1:0] init_calib_complete,
    input  logic [NUM_CH-1:0] data_compare_error,
    input  logic              err_clear,
    output logic              ddr_rst,
    output logic [NUM_CH-1:0] ch_ready,
    output logic              all_ready,
    output logic              calib_fail,
    output logic              calib_lost,
    output logic [NUM_CH-1:0] err_sticky,
    output logic [1:0]        retry_cnt,
    output logic [2:0]        state
`ifdef DDR_ERR_COUNT_EN
    ,
    output logic [NUM_CH*16-1:0] err_count
`endif
);

    typedef enum logic [2:0] {
        ST_PRE      = 3'd0,
        ST_RST      = 3'd1,
        ST_WAIT_CAL = 3'd2,
        ST_READY    = 3'd3,
        ST_FAIL     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ddr_rst_q, ddr_rst_d;
    logic              all_ready_q, all_ready_d;
    logic              calib_fail_q, calib_fail_d;
    logic              calib_lost_q, calib_lost_d;
    logic [1:0]        retry_cnt_q, retry_cnt_d;
    logic [NUM_CH-1:0] err_sticky_q, err_sticky_d;
    logic [NUM_CH-1:0] ch_ready_q, ch_ready_d;
    logic [NUM_CH-1:0] cal_meta_q, cal_meta_d, cal_sync_q, cal_sync_d;
    logic [NUM_CH-1:0] err_meta_q, err_meta_d, err_sync_q, err_sync_d;
    logic              cal_ok;
    logic              retry_req;

    // Disabled channels count as calibrated.
    assign cal_ok = &(cal_sync_q | ~ch_enable);

    always_comb begin
        cal_meta_d   = init_calib_complete;
        cal_sync_d   = cal_meta_q;
        err_meta_d   = data_compare_error;
        err_sync_d   = err_meta_q;
        ch_ready_d   = cal_sync_q & ch_enable;
        err_sticky_d = (err_sticky_q & ~{NUM_CH{err_clear}}) | (err_sync_q & ch_enable);
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        retry_cnt_d  = retry_cnt_q;
        calib_lost_d = calib_lost_q & ~err_clear;
        retry_req    = 1'b0;

        case (state_q)
            ST_PRE: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(PRE_RST_CYCLES - 1)) state_d = ST_RST;
            end
            ST_RST: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(RST_CYCLES - 1)) state_d = ST_WAIT_CAL;
            end
            ST_WAIT_CAL: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cal_ok) state_d = ST_READY;
                else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) retry_req = 1'b1;
            end
            ST_READY: begin
                if (!cal_ok) begin
                    calib_lost_d = 1'b1;
                    retry_req    = 1'b1;
                end
            end
            ST_FAIL: state_d = ST_FAIL;
            default: state_d = ST_PRE;
        endcase

        if (retry_req) begin
            if (int'(retry_cnt_q) < MAX_RETRY) begin
                if (retry_cnt_q != 2'b11) retry_cnt_d = retry_cnt_q + 2'd1;
                state_d = ST_RST;
            end else begin
                state_d = ST_FAIL;
            end
        end

        if (state_d != state_q) cnt_d = '0;

        ddr_rst_d    = (state_d == ST_RST);
        calib_fail_d = (state_d == ST_FAIL);
        // Lags READY entry by one cycle and drops together with the exit edge.
        all_ready_d  = (state_q == ST_READY) && cal_ok;
    end

    always_ff @(posedge core_clk) begin
        if (sys_rst) begin
            state_q      <= ST_PRE;
            cnt_q        <= '0;
            ddr_rst_q    <= 1'b0;
            all_ready_q  <= 1'b0;
            calib_fail_q <= 1'b0;
            calib_lost_q <= 1'b0;
            retry_cnt_q  <= '0;
            err_sticky_q <= '0;
            ch_ready_q   <= '0;
            cal_meta_q   <= '0;
            cal_sync_q   <= '0;
            err_meta_q   <= '0;
            err_sync_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            ddr_rst_q    <= ddr_rst_d;
            all_ready_q  <= all_ready_d;
            calib_fail_q <= calib_fail_d;
            calib_lost_q <= calib_lost_d;
            retry_cnt_q  <= retry_cnt_d;
            err_sticky_q <= err_sticky_d;
            ch_ready_q   <= ch_ready_d;
            cal_meta_q   <= cal_meta_d;
            cal_sync_q   <= cal_sync_d;
            err_meta_q   <= err_meta_d;
            err_sync_q   <= err_sync_d;
        end
    end

    assign ddr_rst    = ddr_rst_q;
    assign ch_ready   = ch_ready_q;
    assign all_ready  = all_ready_q;
    assign calib_fail = calib_fail_q;
    assign calib_lost = calib_lost_q;
    assign err_sticky = err_sticky_q;
    assign retry_cnt  = retry_cnt_q;
    assign state      = state_q;

`ifdef DDR_ERR_COUNT_EN
    logic [NUM_CH-1:0]    err_prev_q, err_prev_d;
    logic [NUM_CH-1:0]    err_rise;
    logic [NUM_CH*16-1:0] err_cnt_q, err_cnt_d;

    assign err_rise = err_sync_q & ~err_prev_q;

    // A rise coinciding with err_clear is counted into the freshly cleared counter.
    always_comb begin
        err_prev_d = err_sync_q;
        err_cnt_d  = err_cnt_q;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (err_clear) begin
                err_cnt_d[i*16 +: 16] = err_rise[i] ? 16'd1 : 16'd0;
            end else if (err_rise[i] && (err_cnt_q[i*16 +: 16] != 16'hFFFF)) begin
                err_cnt_d[i*16 +: 16] = err_cnt_q[i*16 +: 16] + 16'd1;
            end
        end
    end

    always_ff @(posedge core_clk) begin
        if (sys_rst) begin
            err_prev_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            err_prev_q <= err_prev_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_ddr_multi_ch_init_ctrl.sv
// Directed bench for ddr_multi_ch_init_ctrl with a queue scoreboard of expected results.
module tb_ddr_multi_ch_init_ctrl;

    localparam int NUM_CH = 2;

    logic              core_clk = 1'b0;
    logic              sys_rst;
    logic [NUM_CH-1:0] ch_enable;
    logic [NUM_CH-1:0] init_calib_complete;
    logic [NUM_CH-1:0] data_compare_error;
    logic              err_clear;
    logic              ddr_rst;
    logic [NUM_CH-1:0] ch_ready;
    logic              all_ready;
    logic              calib_fail;
    logic              calib_lost;
    logic [NUM_CH-1:0] err_sticky;
    logic [1:0]        retry_cnt;
    logic [2:0]        state;
`ifdef DDR_ERR_COUNT_EN
    logic [NUM_CH*16-1:0] err_count;
`endif

    always #5 core_clk = ~core_clk;

    ddr_multi_ch_init_ctrl #(
        .NUM_CH         (NUM_CH),
        .PRE_RST_CYCLES (4),
        .RST_CYCLES     (8),
        .TIMEOUT_CYCLES (100),
        .MAX_RETRY      (2)
    ) dut (
        .core_clk            (core_clk),
        .sys_rst             (sys_rst),
        .ch_enable           (ch_enable),
        .init_calib_complete (init_calib_complete),
        .data_compare_error  (data_compare_error),
        .err_clear           (err_clear),
        .ddr_rst             (ddr_rst),
        .ch_ready            (ch_ready),
        .all_ready           (all_ready),
        .calib_fail          (calib_fail),
        .calib_lost          (calib_lost),
        .err_sticky          (err_sticky),
        .retry_cnt           (retry_cnt),
        .state               (state)
`ifdef DDR_ERR_COUNT_EN
        ,
        .err_count           (err_count)
`endif
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    task automatic tick();
        @(posedge core_clk);
        #1;
    endtask

    task automatic expect_val(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        exp_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
        end else begin
            e = exp_q.pop_front();
            assert (obs === e.val) else begin
                bad++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic wait_rst_high(output int n);
        n = 0;
        while (ddr_rst !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_rst_low(output int n);
        n = 0;
        while (ddr_rst !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (all_ready !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   n;
        int   rises;
        int   low_len;
        logic prev;
        logic seen_ready;

        // Reset state
        sys_rst = 1'b1;
        ch_enable = 2'b11;
        init_calib_complete = 2'b00;
        data_compare_error = 2'b00;
        err_clear = 1'b0;
        repeat (3) tick();
        expect_val("rst_state", 0);       check(state);
        expect_val("rst_ddr_rst", 0);     check(ddr_rst);
        expect_val("rst_all_ready", 0);   check(all_ready);
        expect_val("rst_calib_fail", 0);  check(calib_fail);
        expect_val("rst_calib_lost", 0);  check(calib_lost);
        expect_val("rst_err_sticky", 0);  check(err_sticky);
        expect_val("rst_retry_cnt", 0);   check(retry_cnt);
        expect_val("rst_ch_ready", 0);    check(ch_ready);

        // 1. Nominal bring-up
        sys_rst = 1'b0;
        expect_val("t1_rst_delay", 4);
        wait_rst_high(n); check(n);
        expect_val("t1_rst_width", 8);
        wait_rst_low(n); check(n);
        expect_val("t1_wait_state", 2);   check(state);
        repeat (20) tick();
        init_calib_complete = 2'b11;
        expect_val("t1_ready_latency", 4);
        wait_ready(n); check(n);
        expect_val("t1_state", 3);        check(state);
        expect_val("t1_retry_cnt", 0);    check(retry_cnt);
        expect_val("t1_ch_ready", 2'b11); check(ch_ready);

        // 2. Timeout and retry into FAIL
        sys_rst = 1'b1;
        init_calib_complete = 2'b01;
        tick();
        expect_val("t2_rst_ddr_rst", 0);  check(ddr_rst);
        expect_val("t2_rst_ready", 0);    check(all_ready);
        tick();
        sys_rst = 1'b0;
        rises = 0;
        low_len = 0;
        prev = 1'b0;
        seen_ready = 1'b0;
        for (int c = 0; c < 2000 && state !== 3'd4; c++) begin
            tick();
            if (all_ready === 1'b1) seen_ready = 1'b1;
            if (ddr_rst === 1'b1 && prev === 1'b0) begin
                rises++;
                if (rises > 1) begin
                    expect_val("t2_retry_gap", 100);
                    check(low_len);
                end
            end
            if (ddr_rst === 1'b0) low_len = (prev === 1'b1) ? 1 : low_len + 1;
            prev = ddr_rst;
        end
        expect_val("t2_rst_pulses", 3);   check(rises);
        expect_val("t2_state", 4);        check(state);
        expect_val("t2_calib_fail", 1);   check(calib_fail);
        expect_val("t2_retry_cnt", 2);    check(retry_cnt);
        expect_val("t2_ready_seen", 0);   check(seen_ready);
        init_calib_complete = 2'b11;
        repeat (10) tick();
        expect_val("t2_fail_terminal", 4); check(state);
        expect_val("t2_fail_ddr_rst", 0);  check(ddr_rst);

        // 3. Channel mask
        sys_rst = 1'b1;
        ch_enable = 2'b01;
        init_calib_complete = 2'b01;
        repeat (2) tick();
        sys_rst = 1'b0;
        wait_rst_high(n);
        wait_rst_low(n);
        data_compare_error = 2'b10;
        expect_val("t3_ready_latency", 2);
        wait_ready(n); check(n);
        data_compare_error = 2'b00;
        repeat (4) tick();
        expect_val("t3_state", 3);          check(state);
        expect_val("t3_err_sticky", 2'b00); check(err_sticky);
        expect_val("t3_ch_ready", 2'b01);   check(ch_ready);

        // 4. Calibration loss for one cycle
        init_calib_complete = 2'b00;
        tick();
        init_calib_complete = 2'b01;
        tick();
        tick();
        expect_val("t4_state_rst", 1);    check(state);
        expect_val("t4_calib_lost", 1);   check(calib_lost);
        expect_val("t4_all_ready", 0);    check(all_ready);
        expect_val("t4_retry_cnt", 1);    check(retry_cnt);
        expect_val("t4_ddr_rst", 1);      check(ddr_rst);
        expect_val("t4_rst_width", 8);
        wait_rst_low(n); check(n);
        expect_val("t4_ready_latency", 2);
        wait_ready(n); check(n);
        expect_val("t4_lost_held", 1);    check(calib_lost);
        expect_val("t4_retry_held", 1);   check(retry_cnt);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        expect_val("t4_lost_cleared", 0); check(calib_lost);
        expect_val("t4_still_ready", 3);  check(state);

        // 5. Sticky error set versus clear in the same cycle
        init_calib_complete = 2'b11;
        repeat (3) tick();
        ch_enable = 2'b11;
        repeat (3) tick();
        expect_val("t5_all_ready", 1);      check(all_ready);
        expect_val("t5_ch_ready", 2'b11);   check(ch_ready);
        data_compare_error = 2'b10;
        tick();
        data_compare_error = 2'b00;
        tick();
        expect_val("t5_sync_latency", 2'b00); check(err_sticky);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        expect_val("t5_set_wins", 2'b10);   check(err_sticky);
`ifdef DDR_ERR_COUNT_EN
        expect_val("t5_cnt_load1", 32'h0001_0000); check(err_count);
`endif
        tick();
        expect_val("t5_sticky_hold", 2'b10); check(err_sticky);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        expect_val("t5_clear_alone", 2'b00); check(err_sticky);
`ifdef DDR_ERR_COUNT_EN
        expect_val("t5_cnt_cleared", 0);     check(err_count);
        repeat (3) begin
            data_compare_error = 2'b10;
            tick();
            data_compare_error = 2'b00;
            tick();
        end
        repeat (4) tick();
        expect_val("t5_cnt_three", 32'h0003_0000); check(err_count);
        repeat (70000) begin
            data_compare_error = 2'b11;
            tick();
            data_compare_error = 2'b00;
            tick();
        end
        repeat (4) tick();
        expect_val("t5_cnt_sat", 32'hFFFF_FFFF); check(err_count);
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
`endif

        // 6. Reset asserted while ddr_rst is high
        sys_rst = 1'b1;
        tick();
        sys_rst = 1'b0;
        expect_val("t6_rst_delay", 4);
        wait_rst_high(n); check(n);
        repeat (2) tick();
        expect_val("t6_in_rst", 1);       check(state);
        sys_rst = 1'b1;
        tick();
        expect_val("t6_ddr_rst_drop", 0); check(ddr_rst);
        expect_val("t6_state_pre", 0);    check(state);
        expect_val("t6_retry_cnt", 0);    check(retry_cnt);
        expect_val("t6_err_sticky", 0);   check(err_sticky);
        sys_rst = 1'b0;
        expect_val("t6_rst_delay2", 4);
        wait_rst_high(n); check(n);
        expect_val("t6_rst_width2", 8);
        wait_rst_low(n); check(n);
        expect_val("t6_ready_latency", 2);
        wait_ready(n); check(n);
        expect_val("t6_state_ready", 3);  check(state);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
